// File: rtl/rf_scoreboard.sv
// Issue-side scoreboard for the 32-entry integer register file.
// Counts pending writes per register and stalls issue on RAW, per-register saturation and total limit.
module rf_scoreboard #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 2,
  parameter int TOT_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [REG_AW-1:0]      issue_rs1,
  input  logic                   issue_rs1_ren,
  input  logic [REG_AW-1:0]      issue_rs2,
  input  logic                   issue_rs2_ren,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic                   issue_rd_wen,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic                   flush,
  output logic [2**REG_AW-1:0]   busy_vec,
  output logic [TOT_W-1:0]       inflight,
  output logic                   wb_err
);

  localparam int NREG = 2**REG_AW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  // pend_q[0] is held at zero so x0 reads never hazard
  logic [NREG-1:0][CNT_W-1:0] pend_q;
  logic [TOT_W-1:0]           inflight_q;
  logic                       wb_err_q;

  logic h1, h2, hsat, htot;
  logic fire, ret, dec, ret_err;

  always_comb begin
    h1   = issue_rs1_ren && (issue_rs1 != '0) && (pend_q[issue_rs1] != '0);
    h2   = issue_rs2_ren && (issue_rs2 != '0) && (pend_q[issue_rs2] != '0);
    hsat = issue_rd_wen && (issue_rd != '0) && (pend_q[issue_rd] == CNT_MAX);
    htot = issue_rd_wen && (issue_rd != '0) && (inflight_q == TOT_MAX);
    issue_ready = !flush && !h1 && !h2 && !hsat && !htot;

    fire    = issue_valid && issue_ready && issue_rd_wen && (issue_rd != '0);
    ret     = wb_valid && (wb_rd != '0) && !flush;
    dec     = ret && (pend_q[wb_rd] != '0);
    ret_err = ret && (pend_q[wb_rd] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      pend_q[0] <= '0;
      if (flush) begin
        pend_q     <= '0;
        inflight_q <= '0;
      end else begin
        for (int r = 1; r < NREG; r++) begin
          if (fire && (issue_rd == REG_AW'(r)) && !(dec && (wb_rd == REG_AW'(r))))
            pend_q[r] <= pend_q[r] + CNT_W'(1);
          else if (dec && (wb_rd == REG_AW'(r)) && !(fire && (issue_rd == REG_AW'(r))))
            pend_q[r] <= pend_q[r] - CNT_W'(1);
        end
        // A fire and a retire in the same cycle cancel in the total count
        if (fire && !dec)
          inflight_q <= inflight_q + TOT_W'(1);
        else if (dec && !fire)
          inflight_q <= inflight_q - TOT_W'(1);
      end
      if (ret_err)
        wb_err_q <= 1'b1;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NREG; r++)
      busy_vec[r] = (pend_q[r] != '0);
  end

  assign inflight = inflight_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios plus randomized traffic
// compared against an integer-array model of pending writes.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic        issue_rs1_ren;
  logic [4:0]  issue_rs2;
  logic        issue_rs2_ren;
  logic [4:0]  issue_rd;
  logic        issue_rd_wen;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_vec;
  logic [3:0]  inflight;
  logic        wb_err;

  rf_scoreboard #(.REG_AW(5), .CNT_W(2), .TOT_W(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs1_ren(issue_rs1_ren),
    .issue_rs2(issue_rs2), .issue_rs2_ren(issue_rs2_ren),
    .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .inflight(inflight), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: number of outstanding writes per register, total, sticky error
  int pend_m[32];
  int infl_m;
  bit err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend_m[r] = 0;
    infl_m = 0;
    err_m  = 1'b0;
  endtask

  function automatic bit model_ready();
    if (flush) return 1'b0;
    if (issue_rs1_ren && issue_rs1 != 0 && pend_m[issue_rs1] != 0) return 1'b0;
    if (issue_rs2_ren && issue_rs2 != 0 && pend_m[issue_rs2] != 0) return 1'b0;
    if (issue_rd_wen && issue_rd != 0 && pend_m[issue_rd] == 3) return 1'b0;
    if (issue_rd_wen && issue_rd != 0 && infl_m == 15) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (pend_m[r] > 0);
    return b;
  endfunction

  task automatic set_in(input bit iv, input logic [4:0] rs1, input bit r1en,
                        input logic [4:0] rs2, input bit r2en,
                        input logic [4:0] rd, input bit wen,
                        input bit wbv, input logic [4:0] wbrd, input bit fl);
    issue_valid = iv;  issue_rs1 = rs1; issue_rs1_ren = r1en;
    issue_rs2 = rs2;   issue_rs2_ren = r2en;
    issue_rd = rd;     issue_rd_wen = wen;
    wb_valid = wbv;    wb_rd = wbrd;    flush = fl;
  endtask

  task automatic issue_w(input logic [4:0] rd);
    set_in(1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
  endtask

  // Check outputs against the model, take one clock edge, then advance the model
  task automatic step();
    bit rdy;
    bit ret_ok;
    #1;
    rdy = model_ready();
    check("ready", {31'b0, issue_ready}, {31'b0, rdy});
    check("busy", busy_vec, model_busy());
    check("inflight", {28'b0, inflight}, infl_m);
    check("wb_err", {31'b0, wb_err}, {31'b0, err_m});
    @(posedge clk);
    if (flush) begin
      for (int r = 0; r < 32; r++) pend_m[r] = 0;
      infl_m = 0;
    end else begin
      ret_ok = wb_valid && wb_rd != 0 && pend_m[wb_rd] > 0;
      if (wb_valid && wb_rd != 0 && pend_m[wb_rd] == 0) err_m = 1'b1;
      if (issue_valid && rdy && issue_rd_wen && issue_rd != 0) begin
        pend_m[issue_rd]++;
        infl_m++;
      end
      if (ret_ok) begin
        pend_m[wb_rd]--;
        infl_m--;
      end
    end
    #1;
  endtask

  function automatic logic [4:0] pick();
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_vec, 32'h0);
    check("rst_inflight", {28'b0, inflight}, 32'd0);
    check("rst_err", {31'b0, wb_err}, 32'd0);
    check("rst_ready", {31'b0, issue_ready}, 32'd1);
    rst = 1'b0;

    // RAW on x5, cleared one cycle after writeback (no same-cycle bypass)
    issue_w(5); step();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("tp1_stall", {31'b0, issue_ready}, 32'd0);
    check("tp1_busy", busy_vec, 32'h20);
    step();
    set_in(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    #1 check("tp1_nobypass", {31'b0, issue_ready}, 32'd0);
    step();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("tp1_unblock", {31'b0, issue_ready}, 32'd1);
    check("tp1_idle", {28'b0, inflight}, 32'd0);
    step();

    // x0 is never tracked
    issue_w(0); step();
    set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0); step();
    check("tp2_inflight", {28'b0, inflight}, 32'd0);

    // Per-register saturation on x7
    for (int k = 0; k < 3; k++) begin issue_w(7); step(); end
    issue_w(7);
    #1 check("tp3_sat", {31'b0, issue_ready}, 32'd0);
    step();
    set_in(1, 0, 0, 0, 0, 7, 1, 1, 7, 0); step();
    issue_w(7);
    #1 check("tp3_resume", {31'b0, issue_ready}, 32'd1);
    step();
    check("tp3_inflight", {28'b0, inflight}, 32'd3);

    // Simultaneous fire and retire
    issue_w(9); step();
    set_in(1, 0, 0, 0, 0, 9, 1, 1, 9, 0); step();
    check("tp4_same_inflight", {28'b0, inflight}, 32'd4);
    issue_w(10); step();
    set_in(1, 0, 0, 0, 0, 9, 1, 1, 10, 0); step();
    check("tp4_busy9", {31'b0, busy_vec[9]}, 32'd1);
    check("tp4_busy10", {31'b0, busy_vec[10]}, 32'd0);

    // Flush discards everything, including the concurrent issue
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    for (int r = 1; r <= 4; r++) begin issue_w(5'(r)); step(); end
    set_in(1, 0, 0, 0, 0, 6, 1, 0, 0, 1);
    #1 check("tp5_flush_ready", {31'b0, issue_ready}, 32'd0);
    step();
    check("tp5_busy", busy_vec, 32'h0);
    check("tp5_inflight", {28'b0, inflight}, 32'd0);

    // Total in-flight limit
    for (int r = 1; r <= 5; r++)
      for (int k = 0; k < 3; k++) begin issue_w(5'(r)); step(); end
    issue_w(6);
    #1 check("tp7_totlimit", {31'b0, issue_ready}, 32'd0);
    step();
    issue_w(0);
    #1 check("tp7_x0_ok", {31'b0, issue_ready}, 32'd1);
    step();
    check("tp7_inflight", {28'b0, inflight}, 32'd15);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();

    // Sticky writeback error survives flush, cleared only by reset
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 12, 0); step();
    check("tp6_err", {31'b0, wb_err}, 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    check("tp6_err_flush", {31'b0, wb_err}, 32'd1);
    set_in(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("tp6_nostall", {31'b0, issue_ready}, 32'd1);
    step();
    issue_w(3); step();
    #2 rst = 1'b1;
    #1 check("tp6_async_err", {31'b0, wb_err}, 32'd0);
    check("tp6_async_busy", busy_vec, 32'h0);
    model_reset();
    rst = 1'b0;

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom), pick(), 1'($urandom), pick(), 1'($urandom),
             pick(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), pick(),
             ($urandom_range(0, 40) == 0));
      if (i == 300) begin
        #2 rst = 1'b1;
        #1 check("rand_async_rst", {28'b0, inflight}, 32'd0);
        model_reset();
        rst = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Issue-side scoreboard sequencing access to the 32-entry integer register file.
- Tracks outstanding writes per architectural register from issue to writeback.
- Blocks issue on RAW hazards (source has a pending write) and on per-register pending-counter saturation.
- Sits between decode/issue and the register file write port; writeback retires entries, pipeline flush clears all state.

Parameters:
- REG_AW, 5, register address width (32 registers; x0 never tracked)
- CNT_W, 2, width of each per-register pending counter; max pending writes per register = 2^CNT_W-1
- TOT_W, 4, width of total in-flight write counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- issue_valid  input  1  decode presents an instruction
- issue_rs1  input  REG_AW  source 1 address
- issue_rs1_ren  input  1  source 1 is read
- issue_rs2  input  REG_AW  source 2 address
- issue_rs2_ren  input  1  source 2 is read
- issue_rd  input  REG_AW  destination address
- issue_rd_wen  input  1  instruction writes rd
- issue_ready  output  1  issue may proceed this cycle
- wb_valid  input  1  writeback commits a register write this cycle
- wb_rd  input  REG_AW  writeback destination
- flush  input  1  discard all in-flight instructions
- busy_vec  output  32  bit r = 1 when register r has ≥1 pending write
- inflight  output  TOT_W  total outstanding tracked writes
- wb_err  output  1  sticky: writeback to a register with zero pending count

Behaviour:
- State: pend[1..31] (CNT_W bits each), inflight, wb_err. pend[0] is constant 0.
- Reset (asynchronous, rst=1): all pend=0, inflight=0, wb_err=0. Outputs: busy_vec=0, issue_ready=1 when issue_valid sources are clean (combinational), inflight=0, wb_err=0. Reset mid-operation discards all pending state immediately.
- Hazard terms (combinational, from registered state only):
  - h1 = issue_rs1_ren & issue_rs1!=0 & pend[rs1]!=0
  - h2 = same for rs2
  - hsat = issue_rd_wen & rd!=0 & pend[rd]==max
  - htot = issue_rd_wen & rd!=0 & inflight==2^TOT_W-1
- issue_ready = !flush & !h1 & !h2 & !hsat & !htot. Independent of issue_valid.
- No same-cycle writeback bypass: a wb_valid to rs1 in the same cycle does not clear h1. Issue succeeds the following cycle. Latency from wb to unblock is 1 cycle.
- Fire: fire = issue_valid & issue_ready & issue_rd_wen & issue_rd!=0. On fire, pend[rd]+1 and inflight+1 at the next edge.
- Retire: ret = wb_valid & wb_rd!=0 & !flush.
  - If pend[wb_rd]!=0: pend[wb_rd]-1 and inflight-1.
  - If pend[wb_rd]==0: no counter change; wb_err set, and it stays set until rst.
- Simultaneous fire and retire, same register: pend unchanged, inflight unchanged.
- Simultaneous fire and retire, different registers: both applied; inflight unchanged.
- Flush: at the next edge, all pend=0 and inflight=0. Concurrent issue and wb are ignored (issue_ready=0 during flush). wb_err is not cleared.
- WAW: multiple writes to the same rd are permitted up to the saturation limit. The register stays busy until all of them retire.
- busy_vec[r] = (pend[r]!=0); busy_vec[0]=0.
- Counters never wrap: saturation and total-limit stalls guarantee this; underflow is blocked as above.

Test Plan:
- Reset then issue rd=5 (wen), next cycle issue rs1=5 → issue_ready=0, busy_vec[5]=1, inflight=1; wb_valid rd=5 → next cycle issue_ready=1, busy_vec=0, inflight=0.
- Issue rd=0 with wen, then read rs1=0 → no counter change, issue_ready stays 1, inflight=0.
- Three issues to rd=7 with no reads (CNT_W=2) → pend[7]=3; fourth issue to rd=7 sees issue_ready=0. One wb to 7 → fourth issues next cycle, pend stays 3.
- Same cycle: fire rd=9 and wb rd=9 with pend[9]=1 → pend[9]=1, inflight unchanged. Same cycle rd=9 fire, wb rd=10 (pend[10]=1) → busy_vec[9]=1, busy_vec[10]=0.
- Four outstanding writes on regs 1-4, assert flush with issue_valid rd=6 → issue_ready=0 that cycle; next cycle busy_vec=0, inflight=0, pend[6]=0.
- wb_valid rd=12 with pend[12]=0 → wb_err=1 and it stays 1 after a flush; only rst asserted asynchronously mid-cycle clears it. A subsequent issue with rs1=12 is not stalled.
